// File: rtl/prm_scan_rdout.sv
// Readout sequencer: walks the accumulator's 128 words via sel1/sel2, streams each word
// with its index, and accumulates coverage (popcount) and the lowest set edge bit.
module prm_scan_rdout #(
  parameter int WORD_W = 32,
  parameter int N_BANK = 8,
  parameter int N_WORD = 16,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic [2:0]        sel1,
  output logic [7:0]        sel2,
  input  logic [WORD_W-1:0] result_imp,
  output logic [WORD_W-1:0] m_data,
  output logic [6:0]        m_idx,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [12:0]       cover_cnt,
  output logic [11:0]       first_hit,
  output logic              hit_found
);

  localparam logic [6:0] LAST_IDX    = 7'(N_BANK * N_WORD - 1);
  localparam logic [2:0] SETTLE_LAST = 3'(RD_LAT);

  typedef enum logic [1:0] {IDLE, SEL, SEND, FIN} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [6:0]        r_w;
  logic [2:0]        r_settle;
  logic [2:0]        r_sel1;
  logic [3:0]        r_sel2;
  logic [WORD_W-1:0] r_data;
  logic [6:0]        r_idx;
  logic              r_last;
  logic [12:0]       r_cover;
  logic [11:0]       r_first;
  logic              r_hit;

  logic              w_settled;
  logic              w_lastw;
  logic [6:0]        w_inc;
  logic [5:0]        w_pop;
  logic [4:0]        w_low;
  logic              w_any;

  assign w_settled = (r_settle == SETTLE_LAST);
  assign w_lastw   = (r_w == LAST_IDX);
  assign w_inc     = r_w + 7'd1;
  assign w_any     = |result_imp;

  assign sel1      = r_sel1;
  assign sel2      = {4'b0000, r_sel2};
  assign m_data    = r_data;
  assign m_idx     = r_idx;
  assign m_last    = r_last;
  assign cover_cnt = r_cover;
  assign first_hit = r_first;
  assign hit_found = r_hit;

  // Popcount of the sampled word and LSB-first priority encode of its lowest set bit.
  always_comb begin
    w_pop = '0;
    w_low = '0;
    for (int i = 0; i < WORD_W; i++) begin
      w_pop = w_pop + 6'(result_imp[i]);
    end
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (result_imp[i]) w_low = 5'(i);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    m_valid = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = SEL;
      SEL: begin
        busy = 1'b1;
        if (w_settled) w_next = SEND;
      end
      SEND: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        if (m_ready) w_next = w_lastw ? FIN : SEL;
      end
      FIN: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: word walk, settle timing, beat capture and scan statistics.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_w      <= '0;
      r_settle <= '0;
      r_sel1   <= '0;
      r_sel2   <= '0;
      r_data   <= '0;
      r_idx    <= '0;
      r_last   <= 1'b0;
      r_cover  <= '0;
      r_first  <= '0;
      r_hit    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_w      <= '0;
            r_settle <= '0;
            r_sel1   <= '0;
            r_sel2   <= '0;
            r_cover  <= '0;
            r_first  <= '0;
            r_hit    <= 1'b0;
          end
        end
        SEL: begin
          if (!w_settled) begin
            r_settle <= r_settle + 3'd1;
          end else begin
            r_settle <= '0;
            r_data   <= result_imp;
            r_idx    <= r_w;
            r_last   <= w_lastw;
            r_cover  <= r_cover + {7'b0, w_pop};
            if (!r_hit && w_any) begin
              r_first <= {r_w, w_low};
              r_hit   <= 1'b1;
            end
          end
        end
        SEND: begin
          if (m_ready && !w_lastw) begin
            r_w    <= w_inc;
            r_sel1 <= w_inc[6:4];
            r_sel2 <= w_inc[3:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prm_scan_rdout.sv
// Self-checking bench for prm_scan_rdout: a behavioural accumulator image plus a
// stream/statistics model checked by one monitor process.
module tb_prm_scan_rdout;

  localparam int RD_LAT = 1;
  localparam int SCAN_CYCLES = 128 * (RD_LAT + 2) + 1;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic        m_ready;
  logic [2:0]  sel1;
  logic [7:0]  sel2;
  logic [31:0] result_imp;
  logic [31:0] m_data;
  logic [6:0]  m_idx;
  logic        m_valid;
  logic        m_last;
  logic        busy;
  logic        done;
  logic [12:0] cover_cnt;
  logic [11:0] first_hit;
  logic        hit_found;

  logic [31:0] acc [128];

  int checks = 0;
  int errs   = 0;
  int expCover = 0;
  int expFirst = 0;
  int expHit   = 0;
  int timedScan = 0;
  int reqIdle  = 0;
  int seenIdle = 0;
  int expIdx   = 0;
  int cyc      = 0;
  int startCyc = 0;
  int busyCyc  = 0;
  logic prevDone = 1'b0;

  prm_scan_rdout #(.WORD_W(32), .N_BANK(8), .N_WORD(16), .RD_LAT(RD_LAT)) dut (
    .CLK(CLK), .RST(RST), .start(start), .sel1(sel1), .sel2(sel2),
    .result_imp(result_imp), .m_data(m_data), .m_idx(m_idx), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done),
    .cover_cnt(cover_cnt), .first_hit(first_hit), .hit_found(hit_found)
  );

  assign result_imp = acc[{sel1, sel2[3:0]}];

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference statistics straight from the accumulator image, bit by bit.
  task automatic modelScan(output int cov, output int first, output int hit);
    cov = 0; first = 0; hit = 0;
    for (int w = 0; w < 128; w++) begin
      cov += $countones(acc[w]);
      for (int b = 0; b < 32; b++) begin
        if (hit == 0 && acc[w][b]) begin
          hit = 1;
          first = w * 32 + b;
        end
      end
    end
  endtask

  // Single compare process: reset behaviour, beat order/content, end-of-scan statistics.
  always begin
    @(negedge CLK or posedge RST);
    if (RST) begin
      #1;
      checkOutput("rst_valid", {63'b0, m_valid}, 64'd0);
      checkOutput("rst_busy", {63'b0, busy}, 64'd0);
      expIdx = 0;
      busyCyc = 0;
      prevDone = 1'b0;
    end else begin
      cyc++;
      if (reqIdle != seenIdle) begin
        seenIdle = reqIdle;
        checkOutput("idle_busy", {63'b0, busy}, 64'd0);
        checkOutput("idle_valid", {63'b0, m_valid}, 64'd0);
        checkOutput("idle_done", {63'b0, done}, 64'd0);
        checkOutput("idle_sel", {53'b0, sel1, sel2}, 64'd0);
        checkOutput("idle_data", {25'b0, m_data, m_idx}, 64'd0);
        checkOutput("idle_last", {63'b0, m_last}, 64'd0);
        checkOutput("idle_stats", {38'b0, cover_cnt, first_hit, hit_found}, 64'd0);
      end
      checkOutput("sel2_hi", {60'b0, sel2[7:4]}, 64'd0);
      if (prevDone) checkOutput("done_width", {63'b0, done}, 64'd0);
      if (start && !busy && !done) begin
        expIdx = 0;
        startCyc = cyc;
      end
      if (m_valid) begin
        if (expIdx > 127) begin
          checkOutput("extra_beat", 64'(expIdx), 64'd127);
        end else begin
          checkOutput("beat_idx", {57'b0, m_idx}, 64'(expIdx));
          checkOutput("beat_data", {32'b0, m_data}, {32'b0, acc[expIdx]});
          checkOutput("beat_last", {63'b0, m_last}, 64'(expIdx == 127));
          checkOutput("beat_sel", {53'b0, sel1, sel2}, 64'({expIdx[6:4], 4'b0000, expIdx[3:0]}));
        end
        if (m_ready) expIdx++;
      end
      if (done) begin
        checkOutput("beat_count", 64'(expIdx), 64'd128);
        checkOutput("cover_cnt", {51'b0, cover_cnt}, 64'(expCover));
        checkOutput("first_hit", {52'b0, first_hit}, 64'(expFirst));
        checkOutput("hit_found", {63'b0, hit_found}, 64'(expHit));
        if (timedScan != 0) checkOutput("done_cycle", 64'(cyc - startCyc), 64'(SCAN_CYCLES));
      end
      if (busy) busyCyc++;
      else      busyCyc = 0;
      if (busyCyc == 3000) begin
        checks++;
        errs++;
        $display("[TB] FAIL watchdog: busy for %0d cycles, expected scan end", busyCyc);
      end
      prevDone = done;
    end
  end

  task automatic setExp(input int cov, input int first, input int hit, input int timed);
    expCover = cov; expFirst = first; expHit = hit; timedScan = timed;
  endtask

  task automatic useModel(input int timed);
    int c, f, h;
    modelScan(c, f, h);
    setExp(c, f, h, timed);
  endtask

  task automatic fillAcc(input int kind);
    for (int i = 0; i < 128; i++) begin
      case (kind)
        0:       acc[i] = 32'h0;
        1:       acc[i] = 32'hFFFF_FFFF;
        default: acc[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      endcase
    end
  endtask

  // mode 0: ready high; 1: random ready; 2: backpressure at idx 10 + start at idx 20;
  // 3: asynchronous reset at idx 50.
  task automatic applyStimulus(input int mode);
    bit bpDone = 0;
    bit stDone = 0;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (done) break;
      if (mode == 1) m_ready = ($urandom_range(0, 3) != 0);
      if (mode == 2 && m_valid && m_idx == 7'd10 && !bpDone) begin
        bpDone = 1;
        m_ready = 1'b0;
        repeat (5) begin @(posedge CLK); #1; end
        m_ready = 1'b1;
      end
      if (mode == 2 && m_valid && m_idx == 7'd20 && !stDone) begin
        stDone = 1;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
      end
      if (mode == 3 && m_valid && m_idx == 7'd50) begin
        #2 RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        reqIdle++;
        @(posedge CLK); #1;
        return;
      end
      @(posedge CLK); #1;
    end
    m_ready = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
  endtask

  initial begin
    RST = 1'b1;
    start = 1'b0;
    m_ready = 1'b1;
    fillAcc(0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    reqIdle++;
    @(posedge CLK); #1;

    setExp(0, 0, 0, 1);
    applyStimulus(0);

    fillAcc(0);
    acc[31] = 32'h0000_0100;
    setExp(1, 1000, 1, 1);
    applyStimulus(0);

    fillAcc(0);
    acc[1]   = 32'h0000_0100;
    acc[127] = 32'h8000_0000;
    setExp(2, 40, 1, 1);
    applyStimulus(0);

    fillAcc(1);
    setExp(4096, 0, 1, 1);
    applyStimulus(0);

    fillAcc(2);
    useModel(0);
    applyStimulus(2);

    for (int k = 0; k < 3; k++) begin
      fillAcc(2);
      useModel(0);
      applyStimulus(1);
    end

    fillAcc(2);
    useModel(0);
    applyStimulus(3);

    fillAcc(2);
    useModel(1);
    applyStimulus(0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
